// File: rtl/seq_sub_pkg.sv
// Shared types and constants for the digit-serial subtractor family.
// The state encoding and mode codes are common to the controller and the bench-visible interface.
package seq_sub_pkg;

    localparam int st_width = 2;

    typedef enum logic [st_width-1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        NEG  = 2'd2
    } state_t;

    localparam logic MODE_DIFF = 1'b0;
    localparam logic MODE_ABS  = 1'b1;

    // One spare bit so the counter can represent N itself without wrapping.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/seq_sub_datapath.sv
// Operand/result shift registers plus one DIGIT-wide subtract-with-borrow slice.
// During the negate pass the slice computes 0 - RC, consuming RC from the bottom while refilling it from the top.
module seq_sub_datapath import seq_sub_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_regs,
    input  logic             sub_regs,
    input  logic             neg_regs,
    input  logic             clr_borrow,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] rc_next,
    output logic             borrow
);

    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rc;
    logic             borrow_r;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT:0]   diff_full;
    logic [DIGIT-1:0] diff;

    assign a_dig = neg_regs ? '0 : ra[DIGIT-1:0];
    assign b_dig = neg_regs ? rc[DIGIT-1:0] : rb[DIGIT-1:0];

    // The extra top bit of the (DIGIT+1)-bit difference is the borrow-out.
    assign diff_full = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, borrow_r};
    assign diff      = diff_full[DIGIT-1:0];
    assign borrow    = diff_full[DIGIT];

    assign rc_next = (rc >> DIGIT) | (WIDTH'(diff) << (WIDTH - DIGIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            ra       <= '0;
            rb       <= '0;
            rc       <= '0;
            borrow_r <= 1'b0;
        end else if (load_regs) begin
            ra       <= a;
            rb       <= b;
            rc       <= '0;
            borrow_r <= 1'b0;
        end else if (sub_regs || neg_regs) begin
            ra       <= ra >> DIGIT;
            rb       <= rb >> DIGIT;
            rc       <= rc_next;
            borrow_r <= clr_borrow ? 1'b0 : borrow;
        end
    end

endmodule

// File: rtl/seq_sub_n.sv
// Multi-cycle subtractor with start/rdy handshake: A-B over WIDTH/DIGIT cycles,
// plus an optional second serial pass that negates a negative difference to give |A-B|.
module seq_sub_n import seq_sub_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             neg,
    output logic             rdy
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(N);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             mode_r;
    logic             load_regs;
    logic             sub_regs;
    logic             neg_regs;
    logic             done;
    logic             last;
    logic             go_neg;
    logic             clr_borrow;
    logic             borrow;
    logic [WIDTH-1:0] rc_next;

    assign last       = (cnt == CNT_W'(N - 1));
    assign load_regs  = (state == IDLE) && start;
    assign sub_regs   = (state == SUB);
    assign neg_regs   = (state == NEG);
    assign go_neg     = sub_regs && last && (mode_r == MODE_ABS) && borrow;
    assign done       = (sub_regs || neg_regs) && last && !go_neg;
    assign clr_borrow = (sub_regs || neg_regs) && last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_r <= MODE_DIFF;
            result <= '0;
            neg    <= 1'b0;
            rdy    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_r <= mode;
                        cnt    <= '0;
                        state  <= SUB;
                        rdy    <= 1'b0;
                    end
                end
                SUB: begin
                    cnt <= cnt + 1'b1;
                    if (go_neg) begin
                        cnt   <= '0;
                        state <= NEG;
                    end else if (done) begin
                        result <= rc_next;
                        neg    <= borrow;
                        state  <= IDLE;
                        rdy    <= 1'b1;
                    end
                end
                NEG: begin
                    cnt <= cnt + 1'b1;
                    if (done) begin
                        result <= rc_next;
                        neg    <= 1'b1;
                        state  <= IDLE;
                        rdy    <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    rdy   <= 1'b1;
                end
            endcase
        end
    end

    seq_sub_datapath #(
        .WIDTH(WIDTH),
        .DIGIT(DIGIT)
    ) datapath_0 (
        .clk       (clk),
        .rst       (rst),
        .load_regs (load_regs),
        .sub_regs  (sub_regs),
        .neg_regs  (neg_regs),
        .clr_borrow(clr_borrow),
        .a         (a),
        .b         (b),
        .rc_next   (rc_next),
        .borrow    (borrow)
    );

endmodule
